// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the per-core memory ports, the arbiter and data_memory.
// slave: arbiter view. master: requester/memory environment view.
interface data_mem_arbiter_if #(
  parameter int unsigned NUM_CORES = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16
);
  logic [2*NUM_CORES-1:0]      req_ctrl;
  logic [ADDR_W*NUM_CORES-1:0] req_addr;
  logic [DATA_W*NUM_CORES-1:0] req_wdata;
  logic [NUM_CORES-1:0]        req_ack;
  logic [DATA_W-1:0]           rsp_rdata;
  logic [1:0]                  mem_ctrl;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        busy;

  modport slave (
    input  req_ctrl, req_addr, req_wdata, mem_rdata,
    output req_ack, rsp_rdata, mem_ctrl, mem_addr, mem_wdata, busy
  );

  modport master (
    output req_ctrl, req_addr, req_wdata, mem_rdata,
    input  req_ack, rsp_rdata, mem_ctrl, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Serialises per-core data memory reads/writes onto one single-port memory.
// Round-robin by default; define ARB_FIXED_PRIORITY_EN for lowest-index-wins.
module data_mem_arbiter #(
  parameter int unsigned NUM_CORES   = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic           clock,
  input  logic           reset,
  data_mem_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           mem_ctrl_q, mem_ctrl_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [NUM_CORES-1:0] req_ack_q, req_ack_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 busy_q, busy_d;

  logic [NUM_CORES-1:0] pend;
  logic                 grant_vld;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     cand;

  // Pending = read or write; the reserved encoding counts as idle.
  always_comb begin
    pend = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      pend[i] = (bus.req_ctrl[2*i +: 2] == 2'b01) || (bus.req_ctrl[2*i +: 2] == 2'b10);
    end
  end

`ifdef ARB_FIXED_PRIORITY_EN
  // Lowest pending index wins; scanning downward leaves the lowest as the last hit.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      cand = IDX_W'(i);
      if (pend[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end
`else
  logic [IDX_W-1:0] last_grant_q;

  // Remember the most recently served core as the round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= IDX_W'(NUM_CORES - 1);
    end else if (state_q == DONE) begin
      last_grant_q <= idx_q;
    end
  end

  // First pending core after last_grant; scanning farthest-first leaves the nearest as the last hit.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = int'(NUM_CORES); k >= 1; k--) begin
      cand = IDX_W'((32'(last_grant_q) + 32'(k)) % NUM_CORES);
      if (pend[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end
`endif

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      mem_ctrl_q  <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      req_ack_q   <= '0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      req_ack_q   <= req_ack_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; outputs are computed one cycle ahead so they line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    mem_ctrl_d  = 2'b00;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    req_ack_d   = '0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          idx_d       = grant_idx;
          mem_ctrl_d  = bus.req_ctrl[2*32'(grant_idx) +: 2];
          mem_addr_d  = bus.req_addr[ADDR_W*32'(grant_idx) +: ADDR_W];
          mem_wdata_d = bus.req_wdata[DATA_W*32'(grant_idx) +: DATA_W];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ctrl_q == 2'b10) begin
          req_ack_d[idx_q] = 1'b1;
          state_d          = DONE;
        end else begin
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_rdata_d      = bus.mem_rdata;
          req_ack_d[idx_q] = 1'b1;
          state_d          = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.mem_ctrl  = mem_ctrl_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.req_ack   = req_ack_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a one-cycle-latency memory model.
module tb_data_mem_arbiter;

  localparam int unsigned NC = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  data_mem_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_arbiter #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Memory model: word at address a preloads to 0xA000+a; read data one cycle after ctrl=01.
  logic [DW-1:0] mem [64];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= DW'(16'hA000 + i);
    end else begin
      if (bus.mem_ctrl == 2'b10) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
      if (bus.mem_ctrl == 2'b01) bus.mem_rdata <= mem[bus.mem_addr[5:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int c, input logic [1:0] ctl, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req_ctrl[2*c +: 2]   = ctl;
    bus.req_addr[AW*c +: AW] = a;
    bus.req_wdata[DW*c +: DW] = d;
  endtask

  task automatic wait_ack(output logic [NC-1:0] a, output int cyc);
    a   = '0;
    cyc = 0;
    while (a == '0 && cyc < 20) begin
      tick();
      cyc++;
      a = bus.req_ack;
    end
    if (a == '0) check("ack_timeout", 32'(0), 32'(1));
  endtask

  // Wait for core c's ack, check latency/data, drop the request and step into IDLE.
  task automatic serve(input int c, input int exp_cyc, input logic is_rd, input logic [DW-1:0] exp_d);
    logic [NC-1:0] a;
    int cyc;
    wait_ack(a, cyc);
    check($sformatf("ack_core%0d", c), 32'(a), 32'(1) << c);
    check($sformatf("lat_core%0d", c), 32'(cyc), 32'(exp_cyc));
    if (is_rd) check($sformatf("rdata_core%0d", c), 32'(bus.rsp_rdata), 32'(exp_d));
    set_req(c, 2'b00, '0, '0);
    tick();
    check("ack_clear", 32'(bus.req_ack), 32'(0));
    check("busy_idle", 32'(bus.busy), 32'(0));
  endtask

  initial begin
    bus.req_ctrl  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_ack", 32'(bus.req_ack), 32'(0));
    check("rst_rdata", 32'(bus.rsp_rdata), 32'(0));
    check("rst_ctrl", 32'(bus.mem_ctrl), 32'(0));
    check("rst_addr", 32'(bus.mem_addr), 32'(0));
    check("rst_wdata", 32'(bus.mem_wdata), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    reset = 1'b0;

    // Core 0 write: mem port active in cycle 1 only, ack in cycle 2.
    set_req(0, 2'b10, 16'h0010, 16'hBEEF);
    tick();
    check("w_ctrl_c1", 32'(bus.mem_ctrl), 32'(2));
    check("w_addr_c1", 32'(bus.mem_addr), 32'h0010);
    check("w_wdata_c1", 32'(bus.mem_wdata), 32'hBEEF);
    check("w_busy_c1", 32'(bus.busy), 32'(1));
    check("w_ack_c1", 32'(bus.req_ack), 32'(0));
    tick();
    check("w_ctrl_c2", 32'(bus.mem_ctrl), 32'(0));
    check("w_ack_c2", 32'(bus.req_ack), 32'h0001);
    set_req(0, 2'b00, '0, '0);
    tick();
    check("w_busy_c3", 32'(bus.busy), 32'(0));
    check("w_rdata_kept", 32'(bus.rsp_rdata), 32'(0));

    // Core 3 reads back 0xBEEF: busy in cycles 1..3, ack in cycle 3.
    set_req(3, 2'b01, 16'h0010, 16'h0000);
    tick();
    check("r_ctrl_c1", 32'(bus.mem_ctrl), 32'(1));
    check("r_addr_c1", 32'(bus.mem_addr), 32'h0010);
    check("r_busy_c1", 32'(bus.busy), 32'(1));
    tick();
    check("r_ctrl_c2", 32'(bus.mem_ctrl), 32'(0));
    check("r_busy_c2", 32'(bus.busy), 32'(1));
    check("r_ack_c2", 32'(bus.req_ack), 32'(0));
    tick();
    check("r_ack_c3", 32'(bus.req_ack), 32'h0008);
    check("r_rdata_c3", 32'(bus.rsp_rdata), 32'hBEEF);
    check("r_busy_c3", 32'(bus.busy), 32'(1));
    set_req(3, 2'b00, '0, '0);
    tick();
    check("r_busy_c4", 32'(bus.busy), 32'(0));

    // Core 0 write sets last_grant=0, then cores 0 and 15 contend.
    set_req(0, 2'b10, 16'h0020, 16'h1234);
    serve(0, 2, 1'b0, 16'h0000);
    set_req(0, 2'b01, 16'h0020, 16'h0000);
    set_req(15, 2'b01, 16'h003F, 16'h0000);
`ifdef ARB_FIXED_PRIORITY_EN
    serve(0, 3, 1'b1, 16'h1234);
    serve(15, 3, 1'b1, 16'hA03F);
`else
    serve(15, 3, 1'b1, 16'hA03F);
    serve(0, 3, 1'b1, 16'h1234);
`endif

    // Cores 1, 2, 5 read together; served in index order after last_grant=0.
    set_req(1, 2'b01, 16'h0031, 16'h0000);
    set_req(2, 2'b01, 16'h0032, 16'h0000);
    set_req(5, 2'b01, 16'h0035, 16'h0000);
    serve(1, 3, 1'b1, 16'hA031);
    serve(2, 3, 1'b1, 16'hA032);
    serve(5, 3, 1'b1, 16'hA035);

    // Reset during WAIT of core 4's read aborts it; held request is reissued afterwards.
    set_req(4, 2'b01, 16'h0034, 16'h0000);
    tick();
    check("rst4_ctrl_issue", 32'(bus.mem_ctrl), 32'(1));
    tick();
    check("rst4_busy_wait", 32'(bus.busy), 32'(1));
    reset = 1'b1;
    #1;
    check("rst4_ctrl_now", 32'(bus.mem_ctrl), 32'(0));
    check("rst4_busy_now", 32'(bus.busy), 32'(0));
    check("rst4_ack_now", 32'(bus.req_ack), 32'(0));
    check("rst4_rdata_now", 32'(bus.rsp_rdata), 32'(0));
    tick();
    tick();
    check("rst4_ack_held", 32'(bus.req_ack), 32'(0));
    reset = 1'b0;
    serve(4, 3, 1'b1, 16'hA034);

    // Reserved encoding is ignored; switching to read then works.
    set_req(7, 2'b11, 16'h0037, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rsv_busy%0d", i), 32'(bus.busy), 32'(0));
      check($sformatf("rsv_ctrl%0d", i), 32'(bus.mem_ctrl), 32'(0));
    end
    set_req(7, 2'b01, 16'h0037, 16'h0000);
    serve(7, 3, 1'b1, 16'hA037);

    // Core 9 write wins over core 10; core 10 withdraws before its grant and gets nothing.
    set_req(9, 2'b10, 16'h0005, 16'h5555);
    set_req(10, 2'b01, 16'h0006, 16'h0000);
    tick();
    check("c9_ctrl", 32'(bus.mem_ctrl), 32'(2));
    check("c9_addr", 32'(bus.mem_addr), 32'h0005);
    check("c9_wdata", 32'(bus.mem_wdata), 32'h5555);
    set_req(10, 2'b00, '0, '0);
    tick();
    check("c9_ack", 32'(bus.req_ack), 32'(1) << 9);
    check("c9_rdata_kept", 32'(bus.rsp_rdata), 32'hA037);
    set_req(9, 2'b00, '0, '0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("wd_ack%0d", i), 32'(bus.req_ack), 32'(0));
      check($sformatf("wd_busy%0d", i), 32'(bus.busy), 32'(0));
    end

    // Core 11 reads back the word core 9 wrote.
    set_req(11, 2'b01, 16'h0005, 16'h0000);
    serve(11, 3, 1'b1, 16'h5555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
